// File: rtl/snake_pkg.sv
// rtl/snake_pkg.sv - shared snake types, playfield limits and direction helper
package snake_pkg;

  typedef enum logic [1:0] {
    DIR_RIGHT = 2'b00,
    DIR_UP    = 2'b01,
    DIR_DOWN  = 2'b10,
    DIR_LEFT  = 2'b11
  } dir_t;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_MOVE,
    ST_SCAN,
    ST_DONE
  } seq_state_t;

  localparam int POS_W       = 11;
  localparam int SNAKE_STEP  = 10;
  localparam int SNAKE_X_MIN = 10;
  localparam int SNAKE_X_MAX = 620;
  localparam int SNAKE_Y_MIN = 10;
  localparam int SNAKE_Y_MAX = 460;

  // Opposite directions are bitwise complements in this encoding.
  function automatic logic is_opposite(input dir_t applied, input logic [1:0] req);
    logic [1:0] applied_bits;
    applied_bits = applied;
    return req == ~applied_bits;
  endfunction

endpackage

// File: rtl/snake_seg_regs.sv
// rtl/snake_seg_regs.sv - body segments 1..3, shifted from the head on each move
module snake_seg_regs
  import snake_pkg::*;
#(
  parameter int START_X = 40,
  parameter int START_Y = 20,
  parameter int STEP    = SNAKE_STEP
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  seg_shift,
  input  logic                  seg_init,
  input  logic [POS_W-1:0]      head_x,
  input  logic [POS_W-1:0]      head_y,
  output logic [2:0][POS_W-1:0] seg_x,
  output logic [2:0][POS_W-1:0] seg_y
);

  localparam logic [2:0][POS_W-1:0] INIT_X = {POS_W'(START_X - 3 * STEP),
                                              POS_W'(START_X - 2 * STEP),
                                              POS_W'(START_X - STEP)};
  localparam logic [2:0][POS_W-1:0] INIT_Y = {3{POS_W'(START_Y)}};

  // The head has already advanced when seg_shift arrives, so segment 1
  // takes the head value delayed by one cycle.
  logic [POS_W-1:0]      prev_x_q, prev_x_d, prev_y_q, prev_y_d;
  logic [2:0][POS_W-1:0] seg_x_q, seg_x_d, seg_y_q, seg_y_d;

  always_comb begin
    prev_x_d = head_x;
    prev_y_d = head_y;
    seg_x_d  = seg_x_q;
    seg_y_d  = seg_y_q;
    if (seg_init) begin
      seg_x_d = INIT_X;
      seg_y_d = INIT_Y;
    end else if (seg_shift) begin
      seg_x_d = {seg_x_q[1:0], prev_x_q};
      seg_y_d = {seg_y_q[1:0], prev_y_q};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      prev_x_q <= POS_W'(START_X);
      prev_y_q <= POS_W'(START_Y);
      seg_x_q  <= INIT_X;
      seg_y_q  <= INIT_Y;
    end else begin
      prev_x_q <= prev_x_d;
      prev_y_q <= prev_y_d;
      seg_x_q  <= seg_x_d;
      seg_y_q  <= seg_y_d;
    end
  end

  assign seg_x = seg_x_q;
  assign seg_y = seg_y_q;

endmodule

// File: rtl/snake_move_sequencer.sv
// rtl/snake_move_sequencer.sv - per-tick head move, wall and bomb collision sequencer
// Define SNAKE_WALL_WRAP_EN to wrap the head at the walls instead of colliding.
module snake_move_sequencer
  import snake_pkg::*;
#(
  parameter int STEP      = SNAKE_STEP,
  parameter int X_MIN     = SNAKE_X_MIN,
  parameter int X_MAX     = SNAKE_X_MAX,
  parameter int Y_MIN     = SNAKE_Y_MIN,
  parameter int Y_MAX     = SNAKE_Y_MAX,
  parameter int NUM_BOMBS = 8,
  parameter int START_X   = 40,
  parameter int START_Y   = 20
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic                         tick,
  input  logic                         run,
  input  logic                         restart,
  input  logic [1:0]                   dir_req,
  input  logic                         dir_req_valid,
  input  logic [10:0]                  bomb_x,
  input  logic [10:0]                  bomb_y,
  output logic [10:0]                  head_x,
  output logic [10:0]                  head_y,
  output logic [1:0]                   direction,
  output logic                         seg_shift,
  output logic                         seg_init,
  output logic [$clog2(NUM_BOMBS)-1:0] bomb_idx,
  output logic                         busy,
  output logic                         update_done,
  output logic                         collision,
  output logic                         tick_overrun
);

  localparam int IDX_W = $clog2(NUM_BOMBS);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(NUM_BOMBS - 1);
  localparam logic [10:0] STEP_C  = 11'(STEP);
  localparam logic [10:0] X_MIN_C = 11'(X_MIN);
  localparam logic [10:0] X_MAX_C = 11'(X_MAX);
  localparam logic [10:0] Y_MIN_C = 11'(Y_MIN);
  localparam logic [10:0] Y_MAX_C = 11'(Y_MAX);

  seq_state_t       state_q, state_d;
  dir_t             dir_q, dir_d, pend_dir_q, pend_dir_d;
  logic [10:0]      head_x_q, head_x_d, head_y_q, head_y_d;
  logic [IDX_W-1:0] bomb_idx_q, bomb_idx_d;
  logic             hit_q, hit_d, collision_q, collision_d, overrun_q, overrun_d;
  logic             seg_shift_q, seg_shift_d, seg_init_q, seg_init_d;
  logic             update_done_q, update_done_d, busy_q, busy_d;

  logic [10:0] nx, ny, mx, my;
  logic        wall_hit, bomb_match;

  // Candidate head for the move; underflow lands above the max limit.
  always_comb begin
    nx = head_x_q;
    ny = head_y_q;
    case (pend_dir_q)
      DIR_RIGHT: nx = head_x_q + STEP_C;
      DIR_LEFT:  nx = head_x_q - STEP_C;
      DIR_UP:    ny = head_y_q - STEP_C;
      default:   ny = head_y_q + STEP_C;
    endcase
    mx       = nx;
    my       = ny;
    wall_hit = 1'b0;
`ifdef SNAKE_WALL_WRAP_EN
    if (nx < X_MIN_C) mx = X_MAX_C;
    else if (nx > X_MAX_C) mx = X_MIN_C;
    if (ny < Y_MIN_C) my = Y_MAX_C;
    else if (ny > Y_MAX_C) my = Y_MIN_C;
`else
    wall_hit = (nx < X_MIN_C) || (nx > X_MAX_C) || (ny < Y_MIN_C) || (ny > Y_MAX_C);
`endif
  end

  assign bomb_match = (head_x_q == bomb_x) && (head_y_q == bomb_y);

  always_comb begin
    state_d       = state_q;
    dir_d         = dir_q;
    pend_dir_d    = pend_dir_q;
    head_x_d      = head_x_q;
    head_y_d      = head_y_q;
    bomb_idx_d    = bomb_idx_q;
    hit_d         = hit_q;
    collision_d   = collision_q;
    overrun_d     = overrun_q;
    seg_shift_d   = 1'b0;
    seg_init_d    = 1'b0;
    update_done_d = 1'b0;

    // Checked against the applied direction so two quick turns cannot reverse.
    if (dir_req_valid && !is_opposite(dir_q, dir_req)) pend_dir_d = dir_t'(dir_req);
    if (tick && (state_q != ST_IDLE)) overrun_d = 1'b1;

    case (state_q)
      ST_IDLE: begin
        if (tick && run && !collision_q) begin
          state_d     = ST_MOVE;
          dir_d       = pend_dir_q;
          head_x_d    = mx;
          head_y_d    = my;
          hit_d       = wall_hit;
          seg_shift_d = 1'b1;
        end
      end
      ST_MOVE: begin
        state_d    = ST_SCAN;
        bomb_idx_d = '0;
      end
      ST_SCAN: begin
        if (bomb_match) hit_d = 1'b1;
        if (bomb_idx_q == LAST_IDX) begin
          // Resolve on the last entry so collision is valid alongside update_done.
          state_d       = ST_DONE;
          bomb_idx_d    = '0;
          collision_d   = hit_q | bomb_match;
          hit_d         = 1'b0;
          update_done_d = 1'b1;
        end else begin
          bomb_idx_d = bomb_idx_q + 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase

    if (restart) begin
      state_d       = ST_IDLE;
      dir_d         = DIR_RIGHT;
      pend_dir_d    = DIR_RIGHT;
      head_x_d      = 11'(START_X);
      head_y_d      = 11'(START_Y);
      bomb_idx_d    = '0;
      hit_d         = 1'b0;
      collision_d   = 1'b0;
      overrun_d     = 1'b0;
      seg_shift_d   = 1'b0;
      seg_init_d    = 1'b1;
      update_done_d = 1'b0;
    end

    busy_d = (state_d != ST_IDLE);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q       <= ST_IDLE;
      dir_q         <= DIR_RIGHT;
      pend_dir_q    <= DIR_RIGHT;
      head_x_q      <= 11'(START_X);
      head_y_q      <= 11'(START_Y);
      bomb_idx_q    <= '0;
      hit_q         <= 1'b0;
      collision_q   <= 1'b0;
      overrun_q     <= 1'b0;
      seg_shift_q   <= 1'b0;
      seg_init_q    <= 1'b0;
      update_done_q <= 1'b0;
      busy_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      dir_q         <= dir_d;
      pend_dir_q    <= pend_dir_d;
      head_x_q      <= head_x_d;
      head_y_q      <= head_y_d;
      bomb_idx_q    <= bomb_idx_d;
      hit_q         <= hit_d;
      collision_q   <= collision_d;
      overrun_q     <= overrun_d;
      seg_shift_q   <= seg_shift_d;
      seg_init_q    <= seg_init_d;
      update_done_q <= update_done_d;
      busy_q        <= busy_d;
    end
  end

  assign head_x       = head_x_q;
  assign head_y       = head_y_q;
  assign direction    = dir_q;
  assign seg_shift    = seg_shift_q;
  assign seg_init     = seg_init_q;
  assign bomb_idx     = bomb_idx_q;
  assign busy         = busy_q;
  assign update_done  = update_done_q;
  assign collision    = collision_q;
  assign tick_overrun = overrun_q;

endmodule

// File: tb/tb_snake_move_sequencer.sv
// tb/tb_snake_move_sequencer.sv - directed self-checking bench for snake_move_sequencer
module tb_snake_move_sequencer;

  logic        clk, rst_n, tick, run, restart, dir_req_valid;
  logic [1:0]  dir_req;
  logic [10:0] bomb_x, bomb_y, head_x, head_y;
  logic [1:0]  direction;
  logic        seg_shift, seg_init, busy, update_done, collision, tick_overrun;
  logic [2:0]  bomb_idx;
  logic [2:0][10:0] seg_x, seg_y;

  logic [10:0] bx_tab [8];
  logic [10:0] by_tab [8];

  int checks = 0;
  int failures = 0;

  assign bomb_x = bx_tab[bomb_idx];
  assign bomb_y = by_tab[bomb_idx];

  snake_move_sequencer dut (
    .clk(clk), .rst_n(rst_n), .tick(tick), .run(run), .restart(restart),
    .dir_req(dir_req), .dir_req_valid(dir_req_valid),
    .bomb_x(bomb_x), .bomb_y(bomb_y),
    .head_x(head_x), .head_y(head_y), .direction(direction),
    .seg_shift(seg_shift), .seg_init(seg_init), .bomb_idx(bomb_idx),
    .busy(busy), .update_done(update_done), .collision(collision),
    .tick_overrun(tick_overrun)
  );

  snake_seg_regs segs (
    .clk(clk), .rst_n(rst_n), .seg_shift(seg_shift), .seg_init(seg_init),
    .head_x(head_x), .head_y(head_y), .seg_x(seg_x), .seg_y(seg_y)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic pulse_tick(output int lat);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    lat = 1;
    while (update_done !== 1'b1 && lat < 30) begin
      @(negedge clk);
      lat++;
    end
    @(negedge clk);
  endtask

  task automatic do_restart();
    restart = 1'b1;
    @(negedge clk);
    restart = 1'b0;
  endtask

  task automatic send_dir(input logic [1:0] d);
    dir_req = d;
    dir_req_valid = 1'b1;
    @(negedge clk);
    dir_req_valid = 1'b0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; tick = 1'b0; run = 1'b0; restart = 1'b0;
    dir_req = 2'b00; dir_req_valid = 1'b0;
    for (int i = 0; i < 8; i++) begin bx_tab[i] = 11'd2000; by_tab[i] = 11'd2000; end
    #23;
    checks++;
    if (head_x !== 11'd40 || head_y !== 11'd20 || direction !== 2'b00) begin
      failures++; $display("FAIL reset_head got=(%0d,%0d,%0d) exp=(40,20,0)", head_x, head_y, direction);
    end
    checks++;
    if ({seg_shift, seg_init, update_done, collision, tick_overrun, busy} !== 6'b0 || bomb_idx !== 3'd0) begin
      failures++; $display("FAIL reset_flags got=%b idx=%0d exp=000000 idx=0",
        {seg_shift, seg_init, update_done, collision, tick_overrun, busy}, bomb_idx);
    end
    checks++;
    if (seg_x[0] !== 11'd30 || seg_x[2] !== 11'd10 || seg_y[1] !== 11'd20) begin
      failures++; $display("FAIL reset_segs got=(%0d,%0d,%0d) exp=(30,10,20)", seg_x[0], seg_x[2], seg_y[1]);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_first_move();
    int lat;
    run = 1'b1;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (head_x !== 11'd50 || head_y !== 11'd20 || seg_shift !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL move_cycle got=(%0d,%0d) shift=%b busy=%b exp=(50,20) shift=1 busy=1",
        head_x, head_y, seg_shift, busy);
    end
    @(negedge clk);
    checks++;
    if (seg_shift !== 1'b0 || seg_x[0] !== 11'd40 || seg_x[1] !== 11'd30 || seg_x[2] !== 11'd20) begin
      failures++; $display("FAIL seg_shift_once got shift=%b segs=(%0d,%0d,%0d) exp shift=0 segs=(40,30,20)",
        seg_shift, seg_x[0], seg_x[1], seg_x[2]);
    end
    lat = 2;
    while (update_done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 10 || collision !== 1'b0) begin
      failures++; $display("FAIL first_done got lat=%0d col=%b exp lat=10 col=0", lat, collision);
    end
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || update_done !== 1'b0) begin
      failures++; $display("FAIL first_idle got busy=%b done=%b exp 0 0", busy, update_done);
    end
  endtask

  task automatic test_reverse_rejected();
    int lat;
    send_dir(2'b11);
    pulse_tick(lat);
    checks++;
    if (head_x !== 11'd60 || direction !== 2'b00 || lat !== 10) begin
      failures++; $display("FAIL reverse_rejected got x=%0d dir=%0d lat=%0d exp x=60 dir=0 lat=10", head_x, direction, lat);
    end
  endtask

  task automatic test_turns();
    int lat;
    send_dir(2'b01);
    send_dir(2'b11);
    pulse_tick(lat);
    checks++;
    if (direction !== 2'b01 || head_x !== 11'd60 || head_y !== 11'd10) begin
      failures++; $display("FAIL quick_turn_no_reverse got dir=%0d (%0d,%0d) exp dir=1 (60,10)", direction, head_x, head_y);
    end
    send_dir(2'b01);
    send_dir(2'b11);
    pulse_tick(lat);
    checks++;
    if (direction !== 2'b11 || head_x !== 11'd50 || head_y !== 11'd10 || collision !== 1'b0) begin
      failures++; $display("FAIL last_wins got dir=%0d (%0d,%0d) col=%b exp dir=3 (50,10) col=0",
        direction, head_x, head_y, collision);
    end
  endtask

  task automatic test_run_gating();
    run = 1'b0;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    checks++;
    if (busy !== 1'b0 || head_x !== 11'd50 || tick_overrun !== 1'b0) begin
      failures++; $display("FAIL run_low got busy=%b x=%0d ovr=%b exp 0 50 0", busy, head_x, tick_overrun);
    end
    run = 1'b1;
  endtask

  task automatic test_bomb_collision();
    int lat;
    do_restart();
    checks++;
    if (seg_init !== 1'b1 || head_x !== 11'd40 || head_y !== 11'd20 || direction !== 2'b00) begin
      failures++; $display("FAIL restart_load got init=%b (%0d,%0d) dir=%0d exp 1 (40,20) 0", seg_init, head_x, head_y, direction);
    end
    bx_tab[3] = 11'd50; by_tab[3] = 11'd20;
    pulse_tick(lat);
    checks++;
    if (collision !== 1'b1 || lat !== 10) begin
      failures++; $display("FAIL bomb_hit got col=%b lat=%0d exp col=1 lat=10", collision, lat);
    end
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    @(negedge clk);
    checks++;
    if (head_x !== 11'd50 || busy !== 1'b0 || tick_overrun !== 1'b0) begin
      failures++; $display("FAIL tick_after_collision got x=%0d busy=%b ovr=%b exp 50 0 0", head_x, busy, tick_overrun);
    end
    bx_tab[3] = 11'd2000;
    bx_tab[7] = 11'd50; by_tab[7] = 11'd20;
    do_restart();
    checks++;
    if (collision !== 1'b0) begin
      failures++; $display("FAIL restart_clears_col got=%b exp=0", collision);
    end
    pulse_tick(lat);
    checks++;
    if (collision !== 1'b1) begin
      failures++; $display("FAIL bomb_last_entry got col=%b exp=1", collision);
    end
    bx_tab[7] = 11'd2000;
  endtask

  task automatic test_wall();
    int lat;
    do_restart();
    for (int i = 0; i < 58; i++) pulse_tick(lat);
    checks++;
    if (head_x !== 11'd620 || collision !== 1'b0) begin
      failures++; $display("FAIL wall_edge_legal got x=%0d col=%b exp x=620 col=0", head_x, collision);
    end
    pulse_tick(lat);
`ifdef SNAKE_WALL_WRAP_EN
    checks++;
    if (head_x !== 11'd10 || collision !== 1'b0) begin
      failures++; $display("FAIL wall_wrap got x=%0d col=%b exp x=10 col=0", head_x, collision);
    end
`else
    checks++;
    if (head_x !== 11'd630 || collision !== 1'b1) begin
      failures++; $display("FAIL wall_hit got x=%0d col=%b exp x=630 col=1", head_x, collision);
    end
`endif
  endtask

  task automatic test_overrun();
    int lat;
    do_restart();
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    checks++;
    if (tick_overrun !== 1'b1 || busy !== 1'b1) begin
      failures++; $display("FAIL overrun_flag got ovr=%b busy=%b exp 1 1", tick_overrun, busy);
    end
    lat = 5;
    while (update_done !== 1'b1 && lat < 30) begin @(negedge clk); lat++; end
    checks++;
    if (lat !== 10 || head_x !== 11'd50) begin
      failures++; $display("FAIL overrun_completes got lat=%0d x=%0d exp lat=10 x=50", lat, head_x);
    end
    @(negedge clk);
  endtask

  task automatic test_restart_mid_scan();
    int dones;
    tick = 1'b1;
    @(negedge clk);
    tick = 1'b0;
    repeat (3) @(negedge clk);
    do_restart();
    checks++;
    if (head_x !== 11'd40 || head_y !== 11'd20 || seg_init !== 1'b1 || busy !== 1'b0
        || tick_overrun !== 1'b0 || bomb_idx !== 3'd0) begin
      failures++; $display("FAIL restart_abort got (%0d,%0d) init=%b busy=%b ovr=%b idx=%0d exp (40,20) 1 0 0 0",
        head_x, head_y, seg_init, busy, tick_overrun, bomb_idx);
    end
    dones = 0;
    for (int i = 0; i < 15; i++) begin
      @(negedge clk);
      if (update_done === 1'b1) dones++;
    end
    checks++;
    if (dones !== 0 || seg_x[0] !== 11'd30) begin
      failures++; $display("FAIL restart_no_done got dones=%0d seg1x=%0d exp 0 30", dones, seg_x[0]);
    end
  endtask

  task automatic test_back_to_back();
    int lat1, lat2;
    pulse_tick(lat1);
    pulse_tick(lat2);
    checks++;
    if (head_x !== 11'd60 || lat1 !== 10 || lat2 !== 10 || tick_overrun !== 1'b0) begin
      failures++; $display("FAIL back_to_back got x=%0d lat=%0d,%0d ovr=%b exp x=60 lat=10,10 ovr=0",
        head_x, lat1, lat2, tick_overrun);
    end
  endtask

  initial begin
    test_reset();
    test_first_move();
    test_reverse_rejected();
    test_turns();
    test_run_gating();
    test_bomb_collision();
    test_wall();
    test_overrun();
    test_restart_mid_scan();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
